// File: rtl/core_control_fsm_if.sv
// Core-side bundle for core_control_fsm: instruction/flag/memory inputs in,
// datapath strobes, operand selects and status out.
interface core_control_fsm_if;
    logic [15:0] ir;
    logic        z;
    logic        n;
    logic        cout;
    logic        mem_ready;

    logic        ir_load;
    logic        pc_inc;
    logic        pc_load;
    logic [7:0]  pc_target;
    logic        reg_we;
    logic [2:0]  reg_waddr;
    logic [2:0]  reg_raddr_a;
    logic [2:0]  reg_raddr_b;
    logic [3:0]  alu_op;
    logic        alu_src_imm;
    logic [15:0] imm;
    logic        flags_we;
    logic        mem_req;
    logic        mem_we;
    logic        halted;
    logic        fault;
    logic [2:0]  state;
    logic [15:0] instr_count;

    modport master (
        input  ir, z, n, cout, mem_ready,
        output ir_load, pc_inc, pc_load, pc_target, reg_we, reg_waddr,
               reg_raddr_a, reg_raddr_b, alu_op, alu_src_imm, imm, flags_we,
               mem_req, mem_we, halted, fault, state, instr_count
    );

    modport slave (
        output ir, z, n, cout, mem_ready,
        input  ir_load, pc_inc, pc_load, pc_target, reg_we, reg_waddr,
               reg_raddr_a, reg_raddr_b, alu_op, alu_src_imm, imm, flags_we,
               mem_req, mem_we, halted, fault, state, instr_count
    );
endinterface

// File: rtl/core_control_fsm.sv
// Multi-cycle control FSM for a 16-bit accumulator-less RISC core:
// FETCH/DECODE/EXEC with optional MEM (bounded wait) and WB phases.
module core_control_fsm #(
    parameter int MEM_TIMEOUT = 15
) (
    input logic                 clock_50,
    input logic                 reset_n,
    core_control_fsm_if.master  core
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;
    localparam logic [2:0] S_FAULT  = 3'd6;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_LD   = 4'h9;
    localparam logic [3:0] OP_ST   = 4'hA;
    localparam logic [3:0] OP_BZ   = 4'hB;
    localparam logic [3:0] OP_BN   = 4'hC;
    localparam logic [3:0] OP_BC   = 4'hD;
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [4:0] TIMEOUT = 5'(MEM_TIMEOUT);

    logic [2:0]  state_reg, state_next;
    logic [15:0] ir_reg;
    logic [3:0]  wait_reg, wait_next;
    logic [15:0] count_reg;

    logic        ir_load_c, pc_inc_c, pc_load_c, reg_we_c, flags_we_c;
    logic        mem_req_c, mem_we_c, alu_src_imm_c, cond_c;
    logic [7:0]  pc_target_c;
    logic [2:0]  waddr_c, raddr_a_c, raddr_b_c;
    logic [3:0]  alu_op_c;
    logic [15:0] imm_c;

    // Everything past DECODE works from the latched instruction, never from core.ir.
    logic [3:0] op;
    logic [2:0] rd, rs, rt;
    logic [7:0] imm8;
    assign op   = ir_reg[15:12];
    assign rd   = ir_reg[11:9];
    assign rs   = ir_reg[8:6];
    assign rt   = ir_reg[5:3];
    assign imm8 = ir_reg[7:0];

    always_comb begin
        state_next    = state_reg;
        wait_next     = wait_reg;
        ir_load_c     = 1'b0;
        pc_inc_c      = 1'b0;
        pc_load_c     = 1'b0;
        pc_target_c   = 8'h00;
        reg_we_c      = 1'b0;
        waddr_c       = 3'd0;
        raddr_a_c     = 3'd0;
        raddr_b_c     = 3'd0;
        alu_op_c      = 4'h0;
        alu_src_imm_c = 1'b0;
        imm_c         = 16'h0000;
        flags_we_c    = 1'b0;
        mem_req_c     = 1'b0;
        mem_we_c      = 1'b0;
        cond_c        = 1'b0;
        case (state_reg)
            S_FETCH: begin
                ir_load_c  = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: state_next = S_EXEC;
            S_EXEC: begin
                state_next = S_FETCH;
                case (op)
                    OP_NOP: pc_inc_c = 1'b1;
                    OP_LDI: begin
                        reg_we_c      = 1'b1;
                        waddr_c       = rd;
                        alu_src_imm_c = 1'b1;
                        imm_c         = {8'h00, imm8};
                        pc_inc_c      = 1'b1;
                    end
                    OP_LD, OP_ST: begin
                        state_next = S_MEM;
                        wait_next  = 4'd0;
                    end
                    OP_BZ, OP_BN, OP_BC: begin
                        cond_c = (op == OP_BZ) ? core.z :
                                 (op == OP_BN) ? core.n : core.cout;
                        if (cond_c) begin
                            pc_load_c   = 1'b1;
                            pc_target_c = imm8;
                        end else begin
                            pc_inc_c = 1'b1;
                        end
                    end
                    OP_JMP: begin
                        pc_load_c   = 1'b1;
                        pc_target_c = imm8;
                    end
                    OP_HALT: state_next = S_HALT;
                    default: begin
                        reg_we_c   = 1'b1;
                        flags_we_c = 1'b1;
                        waddr_c    = rd;
                        raddr_a_c  = rs;
                        raddr_b_c  = rt;
                        alu_op_c   = op;
                        pc_inc_c   = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                mem_req_c = 1'b1;
                mem_we_c  = (op == OP_ST);
                raddr_a_c = rs;
                raddr_b_c = rd;
                if (core.mem_ready) begin
                    if (op == OP_ST) begin
                        pc_inc_c   = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end else begin
                    wait_next = wait_reg + 4'd1;
                    if (({1'b0, wait_reg} + 5'd1) == TIMEOUT)
                        state_next = S_FAULT;
                end
            end
            S_WB: begin
                reg_we_c   = 1'b1;
                waddr_c    = rd;
                pc_inc_c   = 1'b1;
                state_next = S_FETCH;
            end
            S_HALT, S_FAULT: state_next = state_reg;
            default: state_next = S_FETCH;
        endcase
        // Reset must silence the datapath immediately, even mid-access.
        if (!reset_n) begin
            ir_load_c     = 1'b0;
            pc_inc_c      = 1'b0;
            pc_load_c     = 1'b0;
            pc_target_c   = 8'h00;
            reg_we_c      = 1'b0;
            waddr_c       = 3'd0;
            raddr_a_c     = 3'd0;
            raddr_b_c     = 3'd0;
            alu_op_c      = 4'h0;
            alu_src_imm_c = 1'b0;
            imm_c         = 16'h0000;
            flags_we_c    = 1'b0;
            mem_req_c     = 1'b0;
            mem_we_c      = 1'b0;
        end
    end

    always_ff @(posedge clock_50) begin
        if (!reset_n) begin
            state_reg <= S_FETCH;
            ir_reg    <= 16'h0000;
            wait_reg  <= 4'd0;
            count_reg <= 16'h0000;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
            if (state_reg == S_DECODE)
                ir_reg <= core.ir;
            if (pc_inc_c || pc_load_c)
                count_reg <= count_reg + 16'd1;
        end
    end

    assign core.ir_load     = ir_load_c;
    assign core.pc_inc      = pc_inc_c;
    assign core.pc_load     = pc_load_c;
    assign core.pc_target   = pc_target_c;
    assign core.reg_we      = reg_we_c;
    assign core.reg_waddr   = waddr_c;
    assign core.reg_raddr_a = raddr_a_c;
    assign core.reg_raddr_b = raddr_b_c;
    assign core.alu_op      = alu_op_c;
    assign core.alu_src_imm = alu_src_imm_c;
    assign core.imm         = imm_c;
    assign core.flags_we    = flags_we_c;
    assign core.mem_req     = mem_req_c;
    assign core.mem_we      = mem_we_c;
    assign core.halted      = (state_reg == S_HALT) || (state_reg == S_FAULT);
    assign core.fault       = (state_reg == S_FAULT);
    assign core.state       = state_reg;
    assign core.instr_count = count_reg;
endmodule

// File: tb/tb_core_control_fsm.sv
// Bench for core_control_fsm: per-instruction cycle plans expanded into a
// vector table, applied cycle by cycle and compared against the DUT.
module tb_core_control_fsm;
    localparam int TIMEOUT = 15;

    logic clock_50 = 1'b0;
    logic reset_n  = 1'b0;
    always #5 clock_50 = ~clock_50;

    core_control_fsm_if bus();

    core_control_fsm #(.MEM_TIMEOUT(TIMEOUT)) dut (
        .clock_50 (clock_50),
        .reset_n  (reset_n),
        .core     (bus)
    );

    typedef struct packed {
        logic        ir_load;
        logic        pc_inc;
        logic        pc_load;
        logic [7:0]  pc_target;
        logic        reg_we;
        logic [2:0]  waddr;
        logic [2:0]  raddr_a;
        logic [2:0]  raddr_b;
        logic [3:0]  alu_op;
        logic        alu_src_imm;
        logic [15:0] imm;
        logic        flags_we;
        logic        mem_req;
        logic        mem_we;
        logic        halted;
        logic        fault;
        logic [2:0]  state;
    } outs_t;

    typedef struct {
        logic        rst_n;
        logic [15:0] ir;
        logic        z, n, c, mem_ready;
        logic        first;
        logic [15:0] instr;
        outs_t       exp;
    } vec_t;

    vec_t        vec_q[$];
    int          checks = 0;
    int          errors = 0;
    int          txn = 0;
    logic [15:0] cnt_model = 16'h0000;

    function automatic outs_t idle(input logic [2:0] st);
        outs_t o = '0;
        o.state  = st;
        o.halted = (st == 3'd5) || (st == 3'd6);
        o.fault  = (st == 3'd6);
        return o;
    endfunction

    function automatic vec_t rnd_vec();
        vec_t v;
        v.rst_n     = 1'b1;
        v.ir        = 16'($urandom);
        v.z         = 1'($urandom);
        v.n         = 1'($urandom);
        v.c         = 1'($urandom);
        v.mem_ready = 1'($urandom);
        v.first     = 1'b0;
        v.instr     = 16'h0000;
        v.exp       = idle(3'd0);
        return v;
    endfunction

    task automatic push_reset(input logic [2:0] st);
        vec_t v = rnd_vec();
        v.rst_n = 1'b0;
        v.exp   = idle(st);
        vec_q.push_back(v);
    endtask

    // Expected cycle-by-cycle behaviour of one instruction, derived from its
    // semantics. rst_at: -1 none, -2 last cycle, else index of the reset cycle.
    task automatic plan(input logic [15:0] instr, input logic zf, input logic nf,
                        input logic cf, input int lat, input int tail, input int rst_at);
        vec_t t[$];
        vec_t v;
        int   stop;
        logic [3:0] op   = instr[15:12];
        logic [2:0] rd   = instr[11:9];
        logic [2:0] rs   = instr[8:6];
        logic [2:0] rt   = instr[5:3];
        logic [7:0] imm8 = instr[7:0];
        logic       taken;

        v = rnd_vec(); v.first = 1'b1; v.instr = instr;
        v.exp = idle(3'd0); v.exp.ir_load = 1'b1; t.push_back(v);
        v = rnd_vec(); v.ir = instr; v.exp = idle(3'd1); t.push_back(v);
        v = rnd_vec(); v.z = zf; v.n = nf; v.c = cf; v.exp = idle(3'd2);
        if (op >= 4'h1 && op <= 4'h7) begin
            v.exp.reg_we = 1'b1; v.exp.flags_we = 1'b1; v.exp.waddr = rd;
            v.exp.raddr_a = rs; v.exp.raddr_b = rt; v.exp.alu_op = op; v.exp.pc_inc = 1'b1;
        end else if (op == 4'h8) begin
            v.exp.reg_we = 1'b1; v.exp.waddr = rd; v.exp.alu_src_imm = 1'b1;
            v.exp.imm = {8'h00, imm8}; v.exp.pc_inc = 1'b1;
        end else if (op == 4'h0) begin
            v.exp.pc_inc = 1'b1;
        end else if (op >= 4'hB && op <= 4'hD) begin
            taken = (op == 4'hB) ? zf : (op == 4'hC) ? nf : cf;
            if (taken) begin v.exp.pc_load = 1'b1; v.exp.pc_target = imm8; end
            else v.exp.pc_inc = 1'b1;
        end else if (op == 4'hE) begin
            v.exp.pc_load = 1'b1; v.exp.pc_target = imm8;
        end
        t.push_back(v);

        if (op == 4'h9 || op == 4'hA) begin
            for (int i = 1; i <= ((lat > TIMEOUT) ? TIMEOUT : lat); i++) begin
                v = rnd_vec(); v.mem_ready = (i == lat); v.exp = idle(3'd3);
                v.exp.mem_req = 1'b1; v.exp.mem_we = (op == 4'hA);
                v.exp.raddr_a = rs; v.exp.raddr_b = rd;
                v.exp.pc_inc = (i == lat) && (op == 4'hA);
                t.push_back(v);
            end
            if (lat > TIMEOUT) begin
                for (int i = 0; i < tail; i++) begin
                    v = rnd_vec(); v.exp = idle(3'd6); t.push_back(v);
                end
            end else if (op == 4'h9) begin
                v = rnd_vec(); v.exp = idle(3'd4);
                v.exp.reg_we = 1'b1; v.exp.waddr = rd; v.exp.pc_inc = 1'b1;
                t.push_back(v);
            end
        end else if (op == 4'hF) begin
            for (int i = 0; i < tail; i++) begin
                v = rnd_vec(); v.exp = idle(3'd5); t.push_back(v);
            end
        end

        stop = (rst_at == -2) ? t.size() - 1 : rst_at;
        for (int i = 0; i < t.size(); i++) begin
            if (i == stop) begin
                push_reset(t[i].exp.state);
                return;
            end
            vec_q.push_back(t[i]);
        end
    endtask

    function automatic outs_t sample();
        outs_t o;
        o.ir_load = bus.ir_load;   o.pc_inc = bus.pc_inc;     o.pc_load = bus.pc_load;
        o.pc_target = bus.pc_target; o.reg_we = bus.reg_we;   o.waddr = bus.reg_waddr;
        o.raddr_a = bus.reg_raddr_a; o.raddr_b = bus.reg_raddr_b; o.alu_op = bus.alu_op;
        o.alu_src_imm = bus.alu_src_imm; o.imm = bus.imm;     o.flags_we = bus.flags_we;
        o.mem_req = bus.mem_req;   o.mem_we = bus.mem_we;     o.halted = bus.halted;
        o.fault = bus.fault;       o.state = bus.state;
        return o;
    endfunction

    task automatic apply_all();
        outs_t got;
        for (int i = 0; i < vec_q.size(); i++) begin
            @(negedge clock_50);
            reset_n       = vec_q[i].rst_n;
            bus.ir        = vec_q[i].ir;
            bus.z         = vec_q[i].z;
            bus.n         = vec_q[i].n;
            bus.cout      = vec_q[i].c;
            bus.mem_ready = vec_q[i].mem_ready;
            #1;
            if (vec_q[i].first) begin
                txn++;
                $display("TXN %0d ir=%h count=%h", txn, vec_q[i].instr, cnt_model);
            end
            got = sample();
            checks++;
            if (got !== vec_q[i].exp) begin
                errors++;
                $display("FAIL outputs vec %0d ir=%h got=%h exp=%h", i, vec_q[i].instr,
                         got, vec_q[i].exp);
            end
            checks++;
            if (bus.instr_count !== cnt_model) begin
                errors++;
                $display("FAIL instr_count vec %0d got=%h exp=%h", i, bus.instr_count, cnt_model);
            end
            if (!vec_q[i].rst_n) cnt_model = 16'h0000;
            else if (vec_q[i].exp.pc_inc || vec_q[i].exp.pc_load) cnt_model = cnt_model + 16'd1;
        end
        vec_q.delete();
    endtask

    initial begin
        int          lat, tail, rst_at;
        logic [15:0] instr;
        logic [3:0]  op;
        bus.ir = 16'h0000; bus.z = 1'b0; bus.n = 1'b0; bus.cout = 1'b0; bus.mem_ready = 1'b0;
        repeat (2) @(posedge clock_50);

        // Directed table
        push_reset(3'd0);
        push_reset(3'd0);
        plan(16'h12A8, 0, 0, 0, 1, 0, -1);
        plan(16'h867F, 0, 0, 0, 1, 0, -1);
        plan(16'hB040, 1, 0, 0, 1, 0, -1);
        plan(16'hB040, 0, 1, 1, 1, 0, -1);
        plan(16'hC011, 0, 1, 0, 1, 0, -1);
        plan(16'hD022, 1, 1, 0, 1, 0, -1);
        plan(16'hE0FF, 0, 0, 0, 1, 0, -1);
        plan(16'h0000, 1, 1, 1, 1, 0, -1);
        plan(16'h9280, 0, 0, 0, 4, 0, -1);
        plan(16'hA280, 0, 0, 0, 2, 0, -1);
        plan(16'h9280, 0, 0, 0, 1, 0, -1);
        plan(16'h9280, 0, 0, 0, TIMEOUT, 0, -1);
        plan(16'h9280, 0, 0, 0, TIMEOUT + 1, 2, -2);
        plan(16'hF000, 0, 0, 0, 1, 20, -2);
        plan(16'hA280, 0, 0, 0, 3, 0, 4);
        plan(16'h7E38, 0, 0, 0, 1, 0, -1);
        apply_all();

        // Randomized program against the same per-instruction model
        for (int k = 0; k < 300; k++) begin
            instr = 16'($urandom);
            op    = instr[15:12];
            lat   = $urandom_range(1, TIMEOUT + 2);
            tail  = $urandom_range(1, 4);
            if (op == 4'hF || ((op == 4'h9 || op == 4'hA) && lat > TIMEOUT)) rst_at = -2;
            else if ($urandom_range(0, 9) == 0) rst_at = $urandom_range(0, 3);
            else rst_at = -1;
            plan(instr, 1'($urandom), 1'($urandom), 1'($urandom), lat, tail, rst_at);
        end
        apply_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
